// File: rtl/mac_pkg.sv
// Shared defaults, requant FSM state encoding and output range limits
// for the mac_psum_requant datapath slice.
package mac_pkg;

  localparam int SUM_WIDTH_DEF = 68;
  localparam int OUT_W_DEF     = 8;
  localparam int OUT_MAX       = 2 ** (OUT_W_DEF - 1) - 1;
  localparam int OUT_MIN       = -(2 ** (OUT_W_DEF - 1));

  typedef enum logic [1:0] {
    ACC = 2'd0,
    RQ1 = 2'd1,
    RQ2 = 2'd2,
    OUT = 2'd3
  } state_t;

endpackage

// File: rtl/requant_round_sat.sv
// Combinational arithmetic right shift (rounding offset already added upstream),
// optional ReLU and signed saturation to OUT_W bits.
module requant_round_sat #(
  parameter int ACC_W = 73,
  parameter int OUT_W = 8
) (
  input  logic [ACC_W-1:0] value,
  input  logic [5:0]       shift,
  input  logic             relu,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] r;

  always_comb begin
    r    = $signed(value) >>> shift;
    data = r[OUT_W-1:0];
    sat  = 1'b0;
    if (relu && r[ACC_W-1]) begin
      data = '0;
    end else if (r > MAXV) begin
      data = MAXV[OUT_W-1:0];
      sat  = 1'b1;
    end else if (r < MINV) begin
      data = MINV[OUT_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/mac_psum_requant.sv
// Accumulates cfg_taps partial sums, adds bias, rounds/shifts, ReLU + saturate,
// valid/ready output. Optional MAC_REQUANT_STATS_EN adds a saturation counter.
module mac_psum_requant
  import mac_pkg::*;
#(
  parameter int SUM_WIDTH = SUM_WIDTH_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int BIAS_W    = 32,
  parameter int TAP_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TAP_W-1:0]     cfg_taps,
  input  logic [5:0]           cfg_shift,
  input  logic [BIAS_W-1:0]    cfg_bias,
  input  logic                 cfg_relu,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_WIDTH-1:0] in_psum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_sat,
  output logic                 busy
`ifdef MAC_REQUANT_STATS_EN
  ,
  output logic [15:0]          sat_count
`endif
);

  localparam int ACC_W = SUM_WIDTH + TAP_W;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   tmp;
  logic [TAP_W-1:0]   tap_cnt;
  logic [TAP_W-1:0]   sh_taps;
  logic [5:0]         sh_shift;
  logic [BIAS_W-1:0]  sh_bias;
  logic               sh_relu;

  logic [TAP_W-1:0]   cfg_taps_eff;
  logic [TAP_W-1:0]   taps_cur;
  logic               last_tap;
  logic [ACC_W-1:0]   psum_ext;
  logic [ACC_W-1:0]   bias_ext;
  logic [ACC_W-1:0]   rnd;
  logic [OUT_W-1:0]   rq_data;
  logic               rq_sat;

  // First psum of a group must see live cfg, later ones the shadow copy.
  always_comb begin
    cfg_taps_eff = (cfg_taps == '0) ? TAP_W'(1) : cfg_taps;
    taps_cur     = (tap_cnt == '0) ? cfg_taps_eff : sh_taps;
    last_tap     = (tap_cnt == taps_cur - TAP_W'(1));
    psum_ext     = {{TAP_W{in_psum[SUM_WIDTH-1]}}, in_psum};
    bias_ext     = {{(ACC_W-BIAS_W){sh_bias[BIAS_W-1]}}, sh_bias};
    rnd          = '0;
    if (sh_shift != '0)
      rnd = {{(ACC_W-1){1'b0}}, 1'b1} << (sh_shift - 6'd1);
  end

  requant_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_rq (
    .value (tmp),
    .shift (sh_shift),
    .relu  (sh_relu),
    .data  (rq_data),
    .sat   (rq_sat)
  );

  assign busy = (state != ACC) || (tap_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      acc       <= '0;
      tmp       <= '0;
      tap_cnt   <= '0;
      sh_taps   <= '0;
      sh_shift  <= '0;
      sh_bias   <= '0;
      sh_relu   <= 1'b0;
`ifdef MAC_REQUANT_STATS_EN
      sat_count <= '0;
`endif
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            if (tap_cnt == '0) begin
              sh_taps  <= cfg_taps_eff;
              sh_shift <= cfg_shift;
              sh_bias  <= cfg_bias;
              sh_relu  <= cfg_relu;
            end
            acc <= acc + psum_ext;
            if (last_tap) begin
              tap_cnt  <= '0;
              in_ready <= 1'b0;
              state    <= RQ1;
            end else begin
              tap_cnt <= tap_cnt + TAP_W'(1);
            end
          end
        end
        RQ1: begin
          tmp   <= acc + bias_ext + rnd;
          state <= RQ2;
        end
        RQ2: begin
          out_data  <= rq_data;
          out_sat   <= rq_sat;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            in_ready  <= 1'b1;
            state     <= ACC;
`ifdef MAC_REQUANT_STATS_EN
            if (out_sat && (sat_count != '1))
              sat_count <= sat_count + 16'd1;
`endif
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
